// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: the segment decode
// table, the blank codes and the digit-index type.
package seg7_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_DECODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_DECODE[hex];

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned input
// snapshots, anti-ghost blanking and a blinking decimal-point cursor.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [2:0]  sel_i,
  input  logic        blink_en_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int TICK_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TICK_W-1:0]  tick_cnt;
  digit_idx_t         digit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;
  logic [31:0]        snap_data;
  digit_idx_t         snap_sel;

  logic       slot_end;
  logic       frame_end;
  logic       is_sel;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign slot_end  = (tick_cnt == TICK_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (digit_idx == 3'd7);
  assign is_sel    = (digit_idx == snap_sel);
  assign nibble    = snap_data[{digit_idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if ((tick_cnt >= TICK_W'(DEAD)) && !(is_sel && blink_en_i && !blink_phase)) begin
      an_next  = ~(8'h01 << digit_idx);
      seg_next = dec_seg;
      dp_next  = ~is_sel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      snap_data   <= '0;
      snap_sel    <= '0;
      an_o        <= AN_OFF;
      seg_o       <= SEG_BLANK;
      dp_o        <= 1'b1;
    end else begin
      an_o  <= an_next;
      seg_o <= seg_next;
      dp_o  <= dp_next;

      tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;
      if (slot_end) digit_idx <= digit_idx + 1'b1;

      // Inputs are only sampled here, so a frame never mixes old and new digits.
      if (frame_end) begin
        snap_data <= data_i;
        snap_sel  <= sel_i;
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomised self-checking bench for seg7_scan_display against a cycle-count
// reference model (slot, frame and blink phase derived arithmetically).
module tb_seg7_scan_display;

  localparam int S     = 4;
  localparam int D     = 1;
  localparam int BF    = 2;
  localparam int FRAME = 8 * S;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic [2:0]  sel_i;
  logic        blink_en_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int passed;
  int total;

  // Reference model state: cycles since reset and the frame's displayed inputs.
  int unsigned n;
  logic [31:0] m_data;
  logic [2:0]  m_sel;

  logic [6:0] ref_table [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_display #(
    .SCAN_DIV     (S),
    .DEAD         (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .sel_i      (sel_i),
    .blink_en_i (blink_en_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  // Predicts the outputs produced by the next clock edge, applies that edge,
  // advances the model and returns at the following falling edge.
  task automatic cycle(output logic [7:0] ea, output logic [6:0] es, output logic ed);
    int          t;
    int          d;
    bit          on;
    logic [31:0] sh;
    t  = int'(n % S);
    d  = int'((n / S) % 8);
    on = (((n / FRAME) / BF) % 2) == 0;
    sh = m_data >> (4 * d);
    ea = 8'hFF;
    es = 7'h7F;
    ed = 1'b1;
    if (t >= D && !(d == int'(m_sel) && blink_en_i && !on)) begin
      ea = ~(8'h01 << d);
      es = ref_table[sh[3:0]];
      ed = (d == int'(m_sel)) ? 1'b0 : 1'b1;
    end
    @(posedge clk);
    if (rst) begin
      ea     = 8'hFF;
      es     = 7'h7F;
      ed     = 1'b1;
      n      = 0;
      m_data = '0;
      m_sel  = '0;
    end else begin
      if (n % FRAME == FRAME - 1) begin
        m_data = data_i;
        m_sel  = sel_i;
      end
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] ea; logic [6:0] es; logic ed;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(ea, es, ed);
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL reset cyc%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 i, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [7:0] ea; logic [6:0] es; logic ed;
    int dp_low;
    dp_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle(ea, es, ed);
      if (dp_o === 1'b0) dp_low++;
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL first_frame n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    total++;
    if (dp_low !== 3) $display("FAIL first_frame_dp_count: got %0d, expected 3", dp_low);
    else passed++;
  endtask

  task automatic test_data_pattern();
    logic [7:0] ea; logic [6:0] es; logic ed;
    logic [6:0] seg0, seg7;
    data_i = 32'h8765_4321; sel_i = 3'd0; blink_en_i = 1'b0;
    seg0 = 7'h7F; seg7 = 7'h7F;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(ea, es, ed);
      if (an_o == 8'hFE) seg0 = seg_o;
      if (an_o == 8'h7F) seg7 = seg_o;
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL data_pattern n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    total++;
    if (seg0 !== 7'h79) $display("FAIL data_slot0: got seg=%h, expected 79", seg0);
    else passed++;
    total++;
    if (seg7 !== 7'h00) $display("FAIL data_slot7: got seg=%h, expected 00", seg7);
    else passed++;
  endtask

  task automatic test_blink();
    logic [7:0] ea; logic [6:0] es; logic ed;
    int lit3;
    sel_i = 3'd3; blink_en_i = 1'b1; lit3 = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      cycle(ea, es, ed);
      if (an_o == 8'hF7) lit3++;
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL blink n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    // Six frames cover at least one full dark pair, so slot 3 is lit for under 6 frames.
    total++;
    if (lit3 == 0 || lit3 >= 6 * (S - D))
      $display("FAIL blink_slot3_lit: got %0d cycles, expected between 1 and %0d", lit3, 6 * (S - D) - 1);
    else passed++;
  endtask

  task automatic test_midframe_change();
    logic [7:0] ea; logic [6:0] es; logic ed;
    logic [6:0] seg0;
    data_i = 32'h0; blink_en_i = 1'b0; sel_i = 3'd0;
    for (int i = 0; i < 2 * FRAME && !(i > 0 && n % FRAME == 0); i++) begin
      cycle(ea, es, ed);
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL midframe_sync n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    for (int i = 0; i < FRAME && n % FRAME != 4 * S; i++) begin
      cycle(ea, es, ed);
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL midframe_pre n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    data_i = 32'hFFFF_FFFF;
    seg0 = 7'h7F;
    for (int i = 0; i < 4 * S + FRAME; i++) begin
      cycle(ea, es, ed);
      if (i >= 4 * S && an_o == 8'hFE) seg0 = seg_o;
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL midframe_post n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
    total++;
    if (seg0 !== 7'h0E) $display("FAIL midframe_next_frame: got seg=%h, expected 0E", seg0);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] ea; logic [6:0] es; logic ed;
    bit found;
    data_i = $urandom; sel_i = 3'd3; blink_en_i = 1'b1; found = 1'b0;
    for (int i = 0; i < 8 * FRAME && !found; i++) begin
      if ((((n / FRAME) / BF) % 2) == 1 && n % FRAME == 5 * S + 1) found = 1'b1;
      else begin
        cycle(ea, es, ed);
        total++;
        if ({an_o, seg_o, dp_o} !== {ea, es, ed})
          $display("FAIL rst_mid_seek n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   n, an_o, seg_o, dp_o, ea, es, ed);
        else passed++;
      end
    end
    total++;
    if (!found) $display("FAIL rst_mid_window: got no dark slot 5 within budget, expected one");
    else passed++;
    rst = 1'b1;
    cycle(ea, es, ed);
    rst = 1'b0;
    total++;
    if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1})
      $display("FAIL rst_mid_blank: got an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an_o, seg_o, dp_o);
    else passed++;
    cycle(ea, es, ed);
    total++;
    if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1})
      $display("FAIL rst_mid_dead: got an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an_o, seg_o, dp_o);
    else passed++;
    cycle(ea, es, ed);
    total++;
    if ({an_o, seg_o, dp_o} !== {8'hFE, 7'h40, 1'b0})
      $display("FAIL rst_mid_restart: got an=%h seg=%h dp=%b, expected an=fe seg=40 dp=0", an_o, seg_o, dp_o);
    else passed++;
    for (int i = 0; i < FRAME; i++) begin
      cycle(ea, es, ed);
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL rst_mid_frame n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
  endtask

  task automatic test_random_scoreboard();
    logic [7:0] ea; logic [6:0] es; logic ed;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if (n % FRAME == 16) begin
        data_i = $urandom;
        sel_i  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) blink_en_i = ~blink_en_i;
      cycle(ea, es, ed);
      total++;
      if ($countones(~an_o) > 1)
        $display("FAIL random_onehot n=%0d: got an=%h, expected at most one low bit", n, an_o);
      else passed++;
      total++;
      if ({an_o, seg_o, dp_o} !== {ea, es, ed})
        $display("FAIL random n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 n, an_o, seg_o, dp_o, ea, es, ed);
      else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0;
    n = 0; m_data = '0; m_sel = '0;
    rst = 1'b1; data_i = '0; sel_i = '0; blink_en_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_data_pattern();
    test_blink();
    test_midframe_change();
    test_reset_midframe();
    test_random_scoreboard();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the button-entry controller's 32-bit, 8-hex-digit value and 3-bit digit-select.
- Time-multiplexes the eight nibbles onto an 8-digit common-anode seven-segment display.
- Marks the selected digit with the decimal point and an optional blink.
- Samples its inputs only at frame boundaries, so a digit edit never tears mid-scan.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (≥ DEAD+2).
- DEAD, 500: blanking cycles at the start of each slot, for anti-ghosting (≥1).
- BLINK_FRAMES, 30: frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- data_i  in  32  eight hex digits; digit k = data_i[4k+3:4k]
- sel_i  in  3  index of the digit being edited
- blink_en_i  in  1  1 = selected digit blinks
- an_o  out  8  digit anodes, active-low; bit k = digit k
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  out  1  decimal point, active-low

Behaviour:
- Reset values (next edge with rst=1):
  - an_o=8'hFF, seg_o=7'h7F, dp_o=1.
  - tick_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=1 (on).
  - snap_data=0, snap_sel=0.
  - Reset asserted mid-frame aborts the scan; no partial state is retained.
- tick_cnt counts 0..SCAN_DIV-1 and wraps.
  - At wrap, digit_idx increments 0..7, and 7 wraps to 0.
- Frame end is tick_cnt==SCAN_DIV-1 and digit_idx==7. At that edge:
  - snap_data<=data_i and snap_sel<=sel_i. These are the only sampling points.
  - frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Consequences:
  - The first frame after reset shows all zeros.
  - An input change becomes visible at the start of the next frame, at most 8*SCAN_DIV cycles later.
- Outputs are registered, with 1-cycle latency from (tick_cnt, digit_idx). Per cycle:
  - tick_cnt<DEAD: an_o=FF, seg_o=7F, dp_o=1.
  - digit_idx==snap_sel and blink_en_i=1 and blink_phase=0: an_o=FF, seg_o=7F, dp_o=1.
  - Otherwise: an_o = ~(1<<digit_idx), seg_o = decode(snap_data nibble digit_idx), dp_o = (digit_idx==snap_sel) ? 0 : 1.
- blink_en_i is not snapshotted; it takes effect the next cycle.
  - When it is 0, blink_phase keeps running but has no effect.
- Decode table (hex→gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariant: at most one an_o bit is low in any cycle.
- Counter widths are $clog2 of the respective parameter. No overflow is possible.

Decomposition:
- Shared package (seg7_pkg):
  - the 16-entry decode constant array;
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF;
  - a digit-index typedef (3-bit).
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out, uses the package table). It is reusable by other display paths.
- The scan/blink/snapshot logic stays in the top module.

Test Plan (SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2):
1. rst=1 for 3 cycles -> an_o=FF, seg_o=7F, dp_o=1. Then release -> first frame: each slot shows 1 cycle of FF, then 3 cycles with an_o=~(1<<k), seg_o=40; dp_o=0 only in slot 0.
2. data_i=32'h8765_4321, sel_i=0, blink_en_i=0, wait one frame -> slot0 seg 79 ('1'), slot1 24, slot3 19, slot7 00 ('8'); dp_o=0 only while an_o=FE.
3. sel_i=3, blink_en_i=1 -> slot 3 alternates lit 2 frames / dark 2 frames (an_o stays FF through slot 3); other slots are unaffected; dp_o=0 during slot 3 when lit.
4. Change data_i from 0 to 32'hFFFF_FFFF while digit_idx=4 -> slots 5..7 of that frame still show 40; all slots show 0E from the next frame.
5. Assert rst for 1 cycle during slot 5 of a blink-dark frame -> outputs are at reset values the next cycle; scan restarts at slot 0 with blink_phase=1 and snap_data=0.
6. Scoreboard over 20 frames with random data/sel -> an_o never has more than one low bit; seg_o always matches the decode of snap_data.
